// File: rtl/morse_timed_decoder.sv
// Morse key-line decoder: times marks and gaps against UNIT_CYCLES, emits A-Z/0-9 codes.
// valid/err fire LETTER_UNITS*UNIT_CYCLES+1 cycles after the first low cycle; no backpressure.
module morse_timed_decoder #(
  parameter int UNIT_CYCLES   = 1000,
  parameter int DASH_UNITS    = 2,
  parameter int LETTER_UNITS  = 3,
  parameter int WORD_UNITS    = 7,
  parameter int GLITCH_CYCLES = 2,
  parameter int MAX_SYM       = 5,
  parameter int CNT_W         = $clog2(WORD_UNITS*UNIT_CYCLES+1)
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       key,
  output logic [5:0] code,
  output logic       valid,
  output logic       err,
  output logic       space,
  output logic       busy
);

  localparam int LEN_W = $clog2(MAX_SYM+1);

  localparam logic [CNT_W-1:0] GLITCH_TH = CNT_W'(GLITCH_CYCLES);
  localparam logic [CNT_W-1:0] DASH_TH   = CNT_W'(DASH_UNITS*UNIT_CYCLES);
  localparam logic [CNT_W-1:0] LETTER_TH = CNT_W'(LETTER_UNITS*UNIT_CYCLES);
  localparam logic [CNT_W-1:0] WORD_TH   = CNT_W'(WORD_UNITS*UNIT_CYCLES);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WGAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_key_q;
  logic [MAX_SYM-1:0] r_sym, w_sym_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic [5:0]         r_code, w_code_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_err, w_err_nxt;
  logic               r_space, w_space_nxt;

  logic               w_dash;
  logic [6:0]         w_lut;
  logic               w_hit;

  // Returns {hit, code} for a (length, pattern) pair; dots are 0, dashes 1, last symbol at LSB.
  function automatic logic [6:0] f_lut(input logic [2:0] l, input logic [4:0] s);
    logic [6:0] r;
    r = 7'd0;
    case ({l, s})
      8'b001_00000: r = {1'b1, 6'd4};
      8'b001_00001: r = {1'b1, 6'd19};
      8'b010_00000: r = {1'b1, 6'd8};
      8'b010_00001: r = {1'b1, 6'd0};
      8'b010_00010: r = {1'b1, 6'd13};
      8'b010_00011: r = {1'b1, 6'd12};
      8'b011_00000: r = {1'b1, 6'd18};
      8'b011_00001: r = {1'b1, 6'd20};
      8'b011_00010: r = {1'b1, 6'd17};
      8'b011_00011: r = {1'b1, 6'd22};
      8'b011_00100: r = {1'b1, 6'd3};
      8'b011_00101: r = {1'b1, 6'd10};
      8'b011_00110: r = {1'b1, 6'd6};
      8'b011_00111: r = {1'b1, 6'd14};
      8'b100_00000: r = {1'b1, 6'd7};
      8'b100_00001: r = {1'b1, 6'd21};
      8'b100_00010: r = {1'b1, 6'd5};
      8'b100_00100: r = {1'b1, 6'd11};
      8'b100_00110: r = {1'b1, 6'd15};
      8'b100_00111: r = {1'b1, 6'd9};
      8'b100_01000: r = {1'b1, 6'd1};
      8'b100_01001: r = {1'b1, 6'd23};
      8'b100_01010: r = {1'b1, 6'd2};
      8'b100_01011: r = {1'b1, 6'd24};
      8'b100_01100: r = {1'b1, 6'd25};
      8'b100_01101: r = {1'b1, 6'd16};
      8'b101_11111: r = {1'b1, 6'd26};
      8'b101_01111: r = {1'b1, 6'd27};
      8'b101_00111: r = {1'b1, 6'd28};
      8'b101_00011: r = {1'b1, 6'd29};
      8'b101_00001: r = {1'b1, 6'd30};
      8'b101_00000: r = {1'b1, 6'd31};
      8'b101_10000: r = {1'b1, 6'd32};
      8'b101_11000: r = {1'b1, 6'd33};
      8'b101_11100: r = {1'b1, 6'd34};
      8'b101_11110: r = {1'b1, 6'd35};
      default:      r = 7'd0;
    endcase
    return r;
  endfunction

  // Duration of the current key level; first cycle of a new level reads 1.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_key_q <= 1'b0;
    end else begin
      r_key_q <= key;
      if (key != r_key_q)
        r_cnt <= CNT_W'(1);
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_dash = (r_cnt >= DASH_TH);
  assign w_lut  = f_lut(r_len[2:0], r_sym[4:0]);
  assign w_hit  = w_lut[6] && (r_len <= LEN_W'(5));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_sym   <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_space <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sym   <= w_sym_nxt;
      r_len   <= w_len_nxt;
      r_ovf   <= w_ovf_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_space <= w_space_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sym_nxt   = r_sym;
    w_len_nxt   = r_len;
    w_ovf_nxt   = r_ovf;
    w_code_nxt  = r_code;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_space_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (key)
          w_state_nxt = MARK;
      end
      MARK: begin
        if (!key) begin
          if (r_cnt < GLITCH_TH) begin
            w_state_nxt = (r_len != '0) ? GAP : IDLE;
          end else begin
            if (r_len == LEN_W'(MAX_SYM)) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_sym_nxt = {r_sym[MAX_SYM-2:0], w_dash};
              w_len_nxt = r_len + 1'b1;
            end
            w_state_nxt = GAP;
          end
        end
      end
      GAP: begin
        // A key rise on the threshold cycle still closes the pending letter.
        if (r_cnt >= LETTER_TH) begin
          if (r_ovf || !w_hit) begin
            w_err_nxt = 1'b1;
          end else begin
            w_valid_nxt = 1'b1;
            w_code_nxt  = w_lut[5:0];
          end
          w_sym_nxt   = '0;
          w_len_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = key ? MARK : WGAP;
        end else if (key) begin
          w_state_nxt = MARK;
        end
      end
      WGAP: begin
        if (key) begin
          w_state_nxt = MARK;
        end else if (r_cnt >= WORD_TH) begin
          w_space_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign code  = r_code;
  assign valid = r_valid;
  assign err   = r_err;
  assign space = r_space;
  assign busy  = (r_state == MARK) || (r_state == GAP);

endmodule

// File: tb/tb_morse_timed_decoder.sv
// Directed bench for morse_timed_decoder with UNIT_CYCLES=4 (dot 4, dash 12, letter gap 12, word gap 28).
module tb_morse_timed_decoder;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       key;
  logic [5:0] code;
  logic       valid;
  logic       err;
  logic       space;
  logic       busy;

  morse_timed_decoder #(.UNIT_CYCLES(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .key   (key),
    .code  (code),
    .valid (valid),
    .err   (err),
    .space (space),
    .busy  (busy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  int n_valid = 0, n_err = 0, n_space = 0;
  int v_cyc = 0, s_cyc = 0, v_code = 0;
  int n_checks = 0, n_errors = 0;
  int fall = 0;
  int bv = 0, be = 0, bs = 0;

  always @(posedge Clock) cyc++;

  // Pulse recorder, sampled mid-cycle.
  always @(negedge Clock) begin
    if (valid === 1'b1) begin
      n_valid++;
      v_cyc  = cyc;
      v_code = int'(code);
    end
    if (err === 1'b1) n_err++;
    if (space === 1'b1) begin
      n_space++;
      s_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic gap(input int n);
    key = 1'b0;
    step(n);
  endtask

  task automatic mark(input int n);
    key = 1'b1;
    step(n);
    key = 1'b0;
    fall = cyc;
  endtask

  task automatic send(input string p);
    for (int i = 0; i < p.len(); i++) begin
      if (i > 0) gap(4);
      if (p[i] == "-") mark(12);
      else mark(4);
    end
  endtask

  task automatic snap();
    bv = n_valid;
    be = n_err;
    bs = n_space;
  endtask

  initial begin
    Reset = 1'b1;
    key   = 1'b0;
    step(3);
    check("rst_code", int'(code), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'(valid) + int'(err) + int'(space), 0);
    Reset = 1'b0;
    snap();
    gap(100);
    check("idle_pulses", (n_valid - bv) + (n_err - be) + (n_space - bs), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_code", int'(code), 0);

    // "A": letter latency and single word-gap space
    snap();
    send(".-");
    check("A_busy_mark", int'(busy), 1);
    gap(5);
    check("A_busy_gap", int'(busy), 1);
    gap(35);
    check("A_nvalid", n_valid - bv, 1);
    check("A_code", v_code, 0);
    check("A_lat", v_cyc - fall, 13);
    check("A_nspace", n_space - bs, 1);
    check("A_space_lat", s_cyc - fall, 29);
    check("A_busy_after", int'(busy), 0);
    gap(100);
    check("A_nspace_long", n_space - bs, 1);
    check("A_nerr", n_err - be, 0);

    // Digits
    send("-----");
    gap(40);
    check("d0_code", v_code, 26);
    check("d0_lat", v_cyc - fall, 13);
    send("----.");
    gap(40);
    check("d9_code", v_code, 35);

    // Mark-length boundary at 2 units
    snap();
    mark(7);
    gap(40);
    check("m7_code", v_code, 4);
    mark(8);
    gap(40);
    check("m8_code", v_code, 19);
    check("m_nvalid", n_valid - bv, 2);

    // 1-cycle blip inside a gap is dropped and restarts the letter timer
    snap();
    mark(4);
    gap(4);
    mark(1);
    gap(40);
    check("glitch_code", v_code, 4);
    check("glitch_nvalid", n_valid - bv, 1);
    check("glitch_lat", v_cyc - fall, 13);

    // Errors keep the previous code
    send("-");
    gap(40);
    check("pre_err_code", int'(code), 19);
    snap();
    send("..--");
    gap(40);
    check("unk_nerr", n_err - be, 1);
    check("unk_nvalid", n_valid - bv, 0);
    check("unk_code", int'(code), 19);
    snap();
    send("......");
    gap(40);
    check("ovf_nerr", n_err - be, 1);
    check("ovf_nvalid", n_valid - bv, 0);
    check("ovf_code", int'(code), 19);
    snap();
    send(".");
    gap(40);
    check("post_err_code", v_code, 4);
    check("post_err_nvalid", n_valid - bv, 1);

    // Reset in the middle of a character
    snap();
    send("--");
    gap(2);
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    gap(60);
    check("midrst_pulses", (n_valid - bv) + (n_err - be) + (n_space - bs), 0);
    check("midrst_code", int'(code), 0);
    check("midrst_busy", int'(busy), 0);
    send("-");
    gap(40);
    check("midrst_T", v_code, 19);

    // Key rises exactly as the letter threshold is reached
    snap();
    send(".");
    gap(12);
    key = 1'b1;
    step(1);
    check("edge_valid", int'(valid), 1);
    check("edge_code", int'(code), 4);
    step(7);
    key = 1'b0;
    fall = cyc;
    gap(40);
    check("edge_next_code", v_code, 19);
    check("edge_next_lat", v_cyc - fall, 13);
    check("edge_nvalid", n_valid - bv, 2);
    check("edge_nspace", n_space - bs, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/morse_timed_decoder.md
Name: morse_timed_decoder

Overview:
- Decodes a single raw Morse key line into character codes by timing mark and space durations against a parametrised unit time.
- Covers A–Z and 0–9.
- Successor to the dot/dash-pulse decoder FSM: it classifies symbols itself, accumulates up to MAX_SYM symbols, and reports letter, word-gap and error events.
- Sits between the synchronised/debounced key input and the character consumer (display/UART).

Parameters:
- UNIT_CYCLES, 1000: clock cycles per Morse unit (dot length); ≥ 2.
- DASH_UNITS, 2: a mark of ≥ DASH_UNITS*UNIT_CYCLES cycles is a dash; shorter is a dot.
- LETTER_UNITS, 3: low time in units that terminates a letter.
- WORD_UNITS, 7: low time in units that signals a word gap; must exceed LETTER_UNITS.
- GLITCH_CYCLES, 2: a mark shorter than this is discarded as noise; must be < DASH_UNITS*UNIT_CYCLES.
- MAX_SYM, 5: maximum symbols per character; ≥ 5.
- CNT_W, $clog2(WORD_UNITS*UNIT_CYCLES+1): duration counter width.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- key  in  1  synchronous key level; 1 = mark (tone on).
- code  out  6  character code: 0–25 = A–Z, 26–35 = digits 0–9; held between events.
- valid  out  1  one-cycle pulse; code is a newly decoded character.
- err  out  1  one-cycle pulse; unknown pattern or symbol overflow.
- space  out  1  one-cycle pulse; word gap detected after a character.
- busy  out  1  high while symbols are pending (states MARK/GAP).

Behaviour:
- Reset: state=IDLE, cnt=0, sym=0, len=0, ovf=0, code=0, valid=err=space=0, busy=0. Reset has priority over all other activity, mid-character included; any partial character is dropped and no pulse is emitted.
- Symbol register:
  - sym holds MAX_SYM bits; dot=0, dash=1.
  - Each new symbol shifts left, entering at the LSB; len counts symbols.
  - Example: A = len 2, sym 01. 0 = len 5, sym 11111.
- Counter cnt:
  - Cleared on every key level change.
  - Increments each cycle at the current level, saturating at all-ones.
  - The first cycle of a new level has cnt=1.
- States:
  - IDLE (no pending symbols, key low):
    - key=1 → MARK.
  - MARK (key high):
    - On key=0 with cnt < GLITCH_CYCLES: discard the mark; go to GAP if len>0, else IDLE; cnt restarts.
    - Otherwise classify: dash if cnt ≥ DASH_UNITS*UNIT_CYCLES, else dot.
    - If len==MAX_SYM, set ovf and leave sym/len unchanged; else shift in and len+1. Go to GAP.
  - GAP (symbols pending, key low):
    - key=1 → MARK; intra-character gap, no event.
    - When cnt reaches LETTER_UNITS*UNIT_CYCLES, in the next cycle:
      - If ovf or (len,sym) is not in the table, pulse err and leave code unchanged.
      - Else load code and pulse valid.
      - Then clear sym/len/ovf and go to WGAP.
    - If key rises on the same cycle cnt reaches the threshold, the letter still completes and MARK begins.
  - WGAP (character ended, key low; cnt continues from the letter gap, not cleared):
    - key=1 → MARK (new character, no space).
    - When cnt reaches WORD_UNITS*UNIT_CYCLES, pulse space once and go to IDLE.
    - IDLE never emits space, so repeated or long silences give exactly one space.
- Marks longer than counter saturation are dashes; there is no timeout in MARK.
- valid, err and space are mutually exclusive and never asserted for more than one cycle.
- busy = (state==MARK)||(state==GAP).
- Latency: valid/err asserts exactly LETTER_UNITS*UNIT_CYCLES+1 cycles after the first low cycle following the last mark.

Test Plan:
All tests use UNIT_CYCLES=4 (dot = 4 cycles high, dash = 12, inter-symbol gap 4).
- Reset, then key low for 100 cycles → valid/err/space stay 0, busy=0, code=0.
- "A":
  - Stimulus: dot, gap 4, dash, then key low.
  - Required: valid 1 cycle with code=0, 13 cycles after the falling edge of the dash.
  - Then space pulses at low cycle 28+1; no second space over a further 100 low cycles.
- "0":
  - Stimulus: five dashes, then letter gap.
  - Required: code=26, valid. Then "9" (----.) → code=35.
- Mark-length boundaries:
  - A 7-cycle mark then letter gap → code=4 (E); an 8-cycle mark → code=19 (T).
  - A 1-cycle glitch inside a gap is ignored: dot, 1-cycle blip, letter gap → E.
- Errors:
  - "..--" → err pulse, code unchanged from the previous character.
  - Six dots → err (overflow).
  - A subsequent "E" then decodes correctly (code=4, valid).
- Reset after two symbols of a pending character → no pulse; next "T" → code=19.
- Key rising on the exact cycle cnt=12 in GAP → valid for the pending character, and the new mark is timed from that cycle.
